// File: rtl/rom_layer_pkg.sv
// Shared definitions for the layered ROM pixel multiplexer.
//   layer_e       : channel index of each image ROM (channel 0 is the background)
//   BG_IDX        : background channel as an integer index
//   TRANSP_KEY_DEF: default transparent colour key (RGB565 magenta)
//   slice_of()    : extracts field idx of a given width from a packed bus
package rom_layer_pkg;

  typedef enum logic [2:0] {
    BACKGROUND = 3'd0,
    POWER_BTN  = 3'd1,
    RED        = 3'd2,
    GREEN      = 3'd3,
    BLUE       = 3'd4,
    YELLOW     = 3'd5,
    WIN        = 3'd6,
    LOSE       = 3'd7
  } layer_e;

  localparam int unsigned BG_IDX         = 32'(BACKGROUND);
  localparam logic [15:0] TRANSP_KEY_DEF = 16'hF81F;

  // Upper bounds for slice_of(): packed buses up to MAX_PACK_W bits,
  // fields up to MAX_SLICE_W bits.
  localparam int unsigned MAX_PACK_W  = 512;
  localparam int unsigned MAX_SLICE_W = 64;

  function automatic logic [MAX_SLICE_W-1:0] slice_of(
    input logic [MAX_PACK_W-1:0] packed_bus,
    input int unsigned           idx,
    input int unsigned           width
  );
    logic [MAX_PACK_W-1:0] shifted;
    logic [MAX_PACK_W-1:0] mask;
    shifted = packed_bus >> (idx * width);
    mask    = (MAX_PACK_W'(1) << width) - MAX_PACK_W'(1);
    return MAX_SLICE_W'(shifted & mask);
  endfunction

endpackage

// File: rtl/rom_layer_mux_if.sv
// Bus bundle between the pixel source, the image ROMs and rom_layer_mux.
//   FRAME_START, SELECTOR, IN_ADDR, IN_VALID : pixel-address stream in
//   CH_ADDR, CH_RD_EN                        : packed per-channel ROM requests
//   CH_PX                                    : packed per-channel ROM data
//   OUT_PX, OUT_VALID, OUT_SEL               : realigned selected pixel
// master = source/ROM side, slave = multiplexer.
interface rom_layer_mux_if #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned PX_W   = 16
);
  logic                   FRAME_START;
  logic [SEL_W-1:0]       SELECTOR;
  logic [ADDR_W-1:0]      IN_ADDR;
  logic                   IN_VALID;
  logic [N_CH*ADDR_W-1:0] CH_ADDR;
  logic [N_CH-1:0]        CH_RD_EN;
  logic [N_CH*PX_W-1:0]   CH_PX;
  logic [PX_W-1:0]        OUT_PX;
  logic                   OUT_VALID;
  logic [SEL_W-1:0]       OUT_SEL;

  modport master (
    output FRAME_START, SELECTOR, IN_ADDR, IN_VALID, CH_PX,
    input  CH_ADDR, CH_RD_EN, OUT_PX, OUT_VALID, OUT_SEL
  );

  modport slave (
    input  FRAME_START, SELECTOR, IN_ADDR, IN_VALID, CH_PX,
    output CH_ADDR, CH_RD_EN, OUT_PX, OUT_VALID, OUT_SEL
  );
endinterface

// File: rtl/rom_layer_delay.sv
// Parametrised shift register with asynchronous active-high reset.
//   clk, rst : clock, async reset (clears every stage)
//   din      : WIDTH-bit word entering stage 0
//   dout     : word after DEPTH clock edges
module rom_layer_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/rom_layer_mux.sv
// Routes one pixel-address stream to one of N_CH image ROMs and realigns the
// returned pixel. Channel 0 is the background layer: it is fetched alongside
// every beat when TRANSP_EN=1 so a transparent foreground pixel can fall
// through to it. Selectors >= N_CH produce DEFAULT_PX.
//   CLK, RST       : clock, asynchronous active-high reset
//   bus.FRAME_START: latches SELECTOR into the frame selector (SYNC_SEL=1)
//   bus.SELECTOR   : requested channel
//   bus.IN_ADDR/IN_VALID : pixel address beat
//   bus.CH_ADDR/CH_RD_EN : registered per-channel ROM requests
//   bus.CH_PX      : per-channel ROM data, ROM_LAT cycles after the request
//   bus.OUT_PX/OUT_VALID/OUT_SEL : result, ROM_LAT+2 cycles after the beat
// Constraints: 2**SEL_W >= N_CH, N_CH*PX_W <= MAX_PACK_W, PX_W <= MAX_SLICE_W.
module rom_layer_mux
  import rom_layer_pkg::*;
#(
  parameter int unsigned     N_CH       = 8,
  parameter int unsigned     SEL_W      = 3,
  parameter int unsigned     ADDR_W     = 16,
  parameter int unsigned     PX_W       = 16,
  parameter int unsigned     ROM_LAT    = 1,
  parameter bit              SYNC_SEL   = 1'b1,
  parameter bit              TRANSP_EN  = 1'b1,
  parameter logic [PX_W-1:0] TRANSP_KEY = PX_W'(TRANSP_KEY_DEF),
  parameter logic [PX_W-1:0] DEFAULT_PX = '0
) (
  input logic           CLK,
  input logic           RST,
  rom_layer_mux_if.slave bus
);

  logic [SEL_W-1:0]       sel_q;
  logic [SEL_W-1:0]       eff_sel;
  logic                   oor;
  logic [N_CH*ADDR_W-1:0] addr_d, addr_q;
  logic [N_CH-1:0]        en_d, en_q;

  logic                   tail_valid;
  logic [SEL_W-1:0]       tail_sel;
  logic                   tail_oor;
  logic [PX_W-1:0]        sel_px, bg_px;
  logic [PX_W-1:0]        out_px_q;
  logic [SEL_W-1:0]       out_sel_q;
  logic                   out_valid_q;

  // A beat coinciding with FRAME_START already uses the new selector.
  assign eff_sel = (!SYNC_SEL || bus.FRAME_START) ? bus.SELECTOR : sel_q;
  assign oor     = (32'(eff_sel) >= N_CH);

  always_comb begin
    addr_d = '0;
    en_d   = '0;
    if (bus.IN_VALID) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if ((!oor && 32'(eff_sel) == k) || (TRANSP_EN && k == BG_IDX)) begin
          en_d[k]                   = 1'b1;
          addr_d[k*ADDR_W +: ADDR_W] = bus.IN_ADDR;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sel_q  <= '0;
      addr_q <= '0;
      en_q   <= '0;
    end else begin
      if (bus.FRAME_START) begin
        sel_q <= bus.SELECTOR;
      end
      addr_q <= addr_d;
      en_q   <= en_d;
    end
  end

  assign bus.CH_ADDR  = addr_q;
  assign bus.CH_RD_EN = en_q;

  // The select travels with the beat so the ROM data it returns can be
  // steered even when the selector changes on every beat.
  rom_layer_delay #(
    .WIDTH (SEL_W + 2),
    .DEPTH (ROM_LAT + 1)
  ) u_align (
    .clk  (CLK),
    .rst  (RST),
    .din  ({bus.IN_VALID, eff_sel, oor}),
    .dout ({tail_valid, tail_sel, tail_oor})
  );

  assign sel_px = PX_W'(slice_of(MAX_PACK_W'(bus.CH_PX), 32'(tail_sel), PX_W));
  assign bg_px  = PX_W'(slice_of(MAX_PACK_W'(bus.CH_PX), BG_IDX, PX_W));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_px_q    <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= tail_valid;
      if (tail_valid) begin
        if (tail_oor) begin
          out_px_q  <= DEFAULT_PX;
          out_sel_q <= tail_sel;
        end else if (TRANSP_EN && tail_sel != '0 && sel_px == TRANSP_KEY) begin
          out_px_q  <= bg_px;
          out_sel_q <= '0;
        end else begin
          out_px_q  <= sel_px;
          out_sel_q <= tail_sel;
        end
      end
    end
  end

  assign bus.OUT_PX    = out_px_q;
  assign bus.OUT_SEL   = out_sel_q;
  assign bus.OUT_VALID = out_valid_q;

endmodule
